ex_operand_stage: RTL and testbench

EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

---
 rtl/ex_operand_stage.sv | 227 ++++++++++++++++++++++
 tb/tb_ex_operand_stage.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// Execute-stage operand register: holds one decoded instruction and presents forwarded ALU operands.
// Latency: one cycle from decode to held; operands, forwarding and stall_id are combinational.
// Backpressure: ex_stall freezes the held instruction and raises stall_id; hazards insert a bubble.
// Optional feature macro ALU_FWD_EN: when defined, operands are forwarded from EX/MEM and MEM/WB;
// when undefined, decode is stalled until any pending writer of a source register has retired.
module ex_operand_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int OPCODE_LENGTH  = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [DATA_WIDTH-1:0]     id_rs1_data,
  input  logic [DATA_WIDTH-1:0]     id_rs2_data,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic [OPCODE_LENGTH-1:0]  id_alu_op,
  input  logic                      id_alusrc,
  input  logic                      id_mem_read,
  input  logic                      id_reg_write,
  input  logic                      flush,
  input  logic                      ex_stall,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic                      exmem_reg_write,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic                      memwb_reg_write,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  output logic [DATA_WIDTH-1:0]     SrcA,
  output logic [DATA_WIDTH-1:0]     SrcB,
  output logic [OPCODE_LENGTH-1:0]  Operation,
  output logic                      ex_valid,
  output logic                      ex_reg_write,
  output logic                      ex_mem_read,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic [DATA_WIDTH-1:0]     ex_store_data,
  output logic                      stall_id
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Held instruction fields
  logic [DATA_WIDTH-1:0]     rs1_data_q;
  logic [DATA_WIDTH-1:0]     rs2_data_q;
  logic [DATA_WIDTH-1:0]     imm_q;
  logic [REG_ADDR_WIDTH-1:0] rs1_q;
  logic [REG_ADDR_WIDTH-1:0] rs2_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic [OPCODE_LENGTH-1:0]  alu_op_q;
  logic                      alusrc_q;
  logic                      mem_read_q;
  logic                      reg_write_q;

  logic                      full;
  logic                      load_use;
  logic                      raw_hazard;
  logic                      load_en;
  logic [DATA_WIDTH-1:0]     rs1_val;
  logic [DATA_WIDTH-1:0]     rs2_val;

  assign full = (state_q == FULL);

  // A load in this stage cannot supply its data in time for a dependent instruction in decode
  always_comb begin
    load_use = 1'b0;
    if (full && mem_read_q && (rd_q != '0) && id_valid &&
        ((id_rs1 == rd_q) || (id_rs2 == rd_q))) begin
      load_use = 1'b1;
    end
  end

`ifdef ALU_FWD_EN

  // Pick the youngest in-flight writer of a source register; x0 is never a forwarding target
  function automatic logic [DATA_WIDTH-1:0] fwd(
    input logic [REG_ADDR_WIDTH-1:0] rs,
    input logic [DATA_WIDTH-1:0]     held,
    input logic [REG_ADDR_WIDTH-1:0] em_rd,
    input logic                      em_we,
    input logic [DATA_WIDTH-1:0]     em_res,
    input logic [REG_ADDR_WIDTH-1:0] mw_rd,
    input logic                      mw_we,
    input logic [DATA_WIDTH-1:0]     mw_res
  );
    logic [DATA_WIDTH-1:0] v;
    v = held;
    if (rs != '0) begin
      if (em_we && (em_rd == rs)) begin
        v = em_res;
      end else if (mw_we && (mw_rd == rs)) begin
        v = mw_res;
      end
    end
    return v;
  endfunction

  // Forwarding muxes, re-evaluated every cycle including while stalled
  always_comb begin
    rs1_val    = fwd(rs1_q, rs1_data_q, exmem_rd, exmem_reg_write, exmem_result,
                     memwb_rd, memwb_reg_write, memwb_result);
    rs2_val    = fwd(rs2_q, rs2_data_q, exmem_rd, exmem_reg_write, exmem_result,
                     memwb_rd, memwb_reg_write, memwb_result);
    raw_hazard = 1'b0;
  end

`else

  logic rs1_dep;
  logic rs2_dep;
  logic unused_nofwd;

  // Without forwarding, a source register written by any instruction still in flight is a hazard
  always_comb begin
    rs1_dep = 1'b0;
    rs2_dep = 1'b0;
    if (id_rs1 != '0) begin
      rs1_dep = (full && reg_write_q && (rd_q == id_rs1)) ||
                (exmem_reg_write && (exmem_rd == id_rs1)) ||
                (memwb_reg_write && (memwb_rd == id_rs1));
    end
    if (id_rs2 != '0) begin
      rs2_dep = (full && reg_write_q && (rd_q == id_rs2)) ||
                (exmem_reg_write && (exmem_rd == id_rs2)) ||
                (memwb_reg_write && (memwb_rd == id_rs2));
    end
    raw_hazard = id_valid && (rs1_dep || rs2_dep);
    rs1_val    = rs1_data_q;
    rs2_val    = rs2_data_q;
  end

  assign unused_nofwd = ^{exmem_result, memwb_result, rs1_q, rs2_q};

`endif

  // Decode must hold on a downstream stall (unless flushed) or on a data hazard; quiet in reset
  always_comb begin
    stall_id = 1'b0;
    if (rst_n) begin
      stall_id = (ex_stall && !flush) || load_use || raw_hazard;
    end
  end

  assign load_en = !flush && !ex_stall && !stall_id && id_valid;

  // Next-state: flush beats stall, stall beats bubble, bubble beats load
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else if (ex_stall) begin
      state_d = state_q;
    end else if (stall_id) begin
      state_d = EMPTY;
    end else if (id_valid) begin
      state_d = FULL;
    end else begin
      state_d = EMPTY;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture decode fields only when an instruction actually enters the stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      alu_op_q    <= '0;
      alusrc_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (load_en) begin
      rs1_data_q  <= id_rs1_data;
      rs2_data_q  <= id_rs2_data;
      imm_q       <= id_imm;
      rs1_q       <= id_rs1;
      rs2_q       <= id_rs2;
      rd_q        <= id_rd;
      alu_op_q    <= id_alu_op;
      alusrc_q    <= id_alusrc;
      mem_read_q  <= id_mem_read;
      reg_write_q <= id_reg_write;
    end
  end

  // Outputs are zeroed whenever the stage is empty so a bubble looks like a no-op downstream
  always_comb begin
    SrcA          = '0;
    SrcB          = '0;
    Operation     = '0;
    ex_valid      = 1'b0;
    ex_reg_write  = 1'b0;
    ex_mem_read   = 1'b0;
    ex_rd         = '0;
    ex_store_data = '0;
    if (full) begin
      SrcA          = rs1_val;
      SrcB          = alusrc_q ? imm_q : rs2_val;
      Operation     = alu_op_q;
      ex_valid      = 1'b1;
      ex_reg_write  = reg_write_q;
      ex_mem_read   = mem_read_q;
      ex_rd         = rd_q;
      ex_store_data = rs2_val;
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

  localparam int DW = 32;
  localparam int OW = 4;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid;
  logic [DW-1:0] id_rs1_data, id_rs2_data, id_imm;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic [OW-1:0] id_alu_op;
  logic          id_alusrc, id_mem_read, id_reg_write;
  logic          flush, ex_stall;
  logic [AW-1:0] exmem_rd, memwb_rd;
  logic          exmem_reg_write, memwb_reg_write;
  logic [DW-1:0] exmem_result, memwb_result;
  logic [DW-1:0] SrcA, SrcB, ex_store_data;
  logic [OW-1:0] Operation;
  logic          ex_valid, ex_reg_write, ex_mem_read, stall_id;
  logic [AW-1:0] ex_rd;

  always #5 clk = ~clk;

  ex_operand_stage #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .REG_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_alusrc(id_alusrc), .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
    .flush(flush), .ex_stall(ex_stall),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_store_data(ex_store_data), .stall_id(stall_id)
  );

  // Reference model: the instruction currently in the stage, or none
  logic          mv;
  logic [DW-1:0] m_rs1d, m_rs2d, m_imm;
  logic [AW-1:0] m_rs1, m_rs2, m_rd;
  logic [OW-1:0] m_op;
  logic          m_alusrc, m_mr, m_rw;

  int total  = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    mv = 0; m_rs1d = 0; m_rs2d = 0; m_imm = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
    m_op = 0; m_alusrc = 0; m_mr = 0; m_rw = 0;
  endtask

`ifdef ALU_FWD_EN
  function automatic logic [DW-1:0] fwd_val(input logic [AW-1:0] r, input logic [DW-1:0] d);
    if (r != 0 && exmem_reg_write && exmem_rd == r) return exmem_result;
    if (r != 0 && memwb_reg_write && memwb_rd == r) return memwb_result;
    return d;
  endfunction
`else
  function automatic logic pending_writer(input logic [AW-1:0] r);
    if (r == 0) return 1'b0;
    return (mv && m_rw && m_rd == r) || (exmem_reg_write && exmem_rd == r) ||
           (memwb_reg_write && memwb_rd == r);
  endfunction
`endif

  function automatic logic exp_stall();
    logic s;
    if (!rst_n) return 1'b0;
    s = (ex_stall && !flush) ||
        (mv && m_mr && m_rd != 0 && id_valid && (id_rs1 == m_rd || id_rs2 == m_rd));
`ifndef ALU_FWD_EN
    s = s || (id_valid && (pending_writer(id_rs1) || pending_writer(id_rs2)));
`endif
    return s;
  endfunction

  task automatic check_all();
    logic [DW-1:0] a, b;
`ifdef ALU_FWD_EN
    a = fwd_val(m_rs1, m_rs1d);
    b = fwd_val(m_rs2, m_rs2d);
`else
    a = m_rs1d;
    b = m_rs2d;
`endif
    if (mv) begin
      check("srca", SrcA, a);
      check("srcb", SrcB, m_alusrc ? m_imm : b);
      check("store", ex_store_data, b);
      check("op", Operation, m_op);
      check("valid", ex_valid, 1);
      check("regw", ex_reg_write, m_rw);
      check("memr", ex_mem_read, m_mr);
      check("rd", ex_rd, m_rd);
    end else begin
      check("srca_empty", SrcA, 0);
      check("srcb_empty", SrcB, 0);
      check("store_empty", ex_store_data, 0);
      check("op_empty", Operation, 0);
      check("valid_empty", ex_valid, 0);
      check("regw_empty", ex_reg_write, 0);
      check("memr_empty", ex_mem_read, 0);
      if (!rst_n) check("rd_reset", ex_rd, 0);
    end
    check("stall_id", stall_id, exp_stall());
  endtask

  // Apply the clock edge to the model using the inputs that were stable before it
  task automatic model_edge();
    if (!rst_n) model_clear();
    else if (flush) mv = 0;
    else if (ex_stall) mv = mv;
    else if (exp_stall()) mv = 0;
    else if (id_valid) begin
      mv = 1; m_rs1d = id_rs1_data; m_rs2d = id_rs2_data; m_imm = id_imm;
      m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_op = id_alu_op;
      m_alusrc = id_alusrc; m_mr = id_mem_read; m_rw = id_reg_write;
    end else mv = 0;
  endtask

  // Inputs are driven at the falling edge; check, then let the rising edge happen
  task automatic cycle();
    #1 check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_instr(input logic v, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                           input logic [AW-1:0] rd, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                           input logic [DW-1:0] imm, input logic [OW-1:0] op,
                           input logic src, input logic mr, input logic rw);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_rs1_data = d1; id_rs2_data = d2;
    id_imm = imm; id_alu_op = op; id_alusrc = src; id_mem_read = mr; id_reg_write = rw;
  endtask

  task automatic clear_wb();
    exmem_rd = 0; exmem_reg_write = 0; exmem_result = 0;
    memwb_rd = 0; memwb_reg_write = 0; memwb_result = 0;
  endtask

  initial begin
    rst_n = 0; flush = 0; ex_stall = 1;
    set_instr(1, 1, 2, 3, 32'h11, 32'h22, 32'h33, 4'h5, 0, 0, 1);
    clear_wb();
    model_clear();
    @(negedge clk);
    // Reset state, with ex_stall high: stall_id must stay low
    cycle();
    ex_stall = 0;
    rst_n = 1;

    // Load-use: load rd=7 held, dependent reads rs2=7
    set_instr(1, 1, 2, 7, 32'hA, 32'hB, 32'h4, 4'h1, 1, 1, 0);
    cycle();
    check("lu_full", ex_valid, 1);
    set_instr(1, 4, 7, 9, 32'hC, 32'hD, 32'h8, 4'h2, 0, 0, 1);
    #1 check("lu_stall", stall_id, 1);
    cycle();
    check("lu_bubble", ex_valid, 0);
    cycle();
    check("lu_capture", ex_valid, 1);
    check("lu_capture_rd", ex_rd, 9);

    // Simultaneous flush and ex_stall while full
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    flush = 1; ex_stall = 1;
    cycle();
    check("flush_stall", ex_valid, 0);
    flush = 0; ex_stall = 0;

    // Asynchronous reset while full and stalled
    set_instr(1, 1, 2, 6, 32'h1234, 32'h5678, 32'h9, 4'h7, 1, 0, 1);
    cycle();
    ex_stall = 1;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    check("pre_reset_valid", ex_valid, 1);
    #2 rst_n = 0;
    model_clear();
    #1;
    check("arst_valid", ex_valid, 0);
    check("arst_srca", SrcA, 0);
    check("arst_srcb", SrcB, 0);
    check("arst_op", Operation, 0);
    check("arst_stall", stall_id, 0);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    rst_n = 1; ex_stall = 0;

`ifdef ALU_FWD_EN
    // Forwarding priority: EX/MEM over MEM/WB over held data
    set_instr(1, 5, 0, 1, 32'h3, 32'h0, 32'h0, 4'h0, 0, 0, 0);
    cycle();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ex_stall = 1;
    exmem_rd = 5; exmem_reg_write = 1; exmem_result = 32'h10;
    memwb_rd = 5; memwb_reg_write = 1; memwb_result = 32'h20;
    #1 check("fwd_exmem", SrcA, 32'h10);
    cycle();
    exmem_reg_write = 0;
    #1 check("fwd_memwb", SrcA, 32'h20);
    cycle();
    ex_stall = 0; clear_wb();
    // x0 is never forwarded
    set_instr(1, 0, 0, 1, 32'h44, 32'h0, 32'h0, 4'h0, 0, 0, 0);
    cycle();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ex_stall = 1;
    exmem_rd = 0; exmem_reg_write = 1; exmem_result = 32'hFF;
    #1 check("fwd_x0", SrcA, 32'h44);
    cycle();
    ex_stall = 0; clear_wb();
`else
    // Without forwarding: ADD rd=3 then a reader of rs1=3 waits three bubbles
    clear_wb();
    set_instr(1, 1, 2, 3, 32'h1, 32'h2, 32'h0, 4'h0, 0, 0, 1);
    cycle();
    set_instr(1, 3, 0, 4, 32'hDEAD, 32'h0, 32'h0, 4'h3, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      #1 check("raw_stall", stall_id, 1);
      cycle();
      check("raw_bubble", ex_valid, 0);
      if (k == 0) begin
        exmem_rd = 3; exmem_reg_write = 1; exmem_result = 32'h1234;
      end else if (k == 1) begin
        exmem_reg_write = 0;
        memwb_rd = 3; memwb_reg_write = 1; memwb_result = 32'h1234;
      end else begin
        memwb_reg_write = 0;
        id_rs1_data = 32'h1234;
      end
    end
    #1 check("raw_release", stall_id, 0);
    cycle();
    check("raw_capture", ex_valid, 1);
    check("raw_value", SrcA, 32'h1234);
    clear_wb();
`endif

    // Randomized traffic with small register indices to provoke hazards often
    for (int n = 0; n < 600; n++) begin
      set_instr($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 4'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom));
      flush    = ($urandom_range(0, 15) == 0);
      ex_stall = ($urandom_range(0, 5) == 0);
      exmem_rd = 5'($urandom_range(0, 7)); exmem_reg_write = 1'($urandom); exmem_result = $urandom;
      memwb_rd = 5'($urandom_range(0, 7)); memwb_reg_write = 1'($urandom); memwb_result = $urandom;
      if (!rst_n) rst_n = 1;
      else if ($urandom_range(0, 63) == 0) begin
        rst_n = 0;
        model_clear();
      end
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
